// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner encodings and default sizes for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_ADDR_W    = 64;
    localparam int DEF_DATA_W    = 64;
    typedef enum logic [1:0] {IDLE, REQ, RDATA, WDATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: icache, dcache and backing-memory burst signals of the arbiter
//   master: arbiter view (drives req_ready/read steering to caches, request/write beats to memory)
//   slave:  environment view (caches and memory)
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_rvalid;
    logic              ic_rlast;
    logic              dc_req_valid;
    logic              dc_req_write;
    logic              dc_req_ready;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wnext;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rvalid;
    logic              dc_last;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    modport master (
        input  ic_req_valid, ic_addr, dc_req_valid, dc_req_write, dc_addr, dc_wdata,
               mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
        output ic_req_ready, ic_rdata, ic_rvalid, ic_rlast,
               dc_req_ready, dc_wnext, dc_rdata, dc_rvalid, dc_last,
               mem_req_valid, mem_req_write, mem_addr, mem_wdata, mem_wvalid
    );
    modport slave (
        output ic_req_valid, ic_addr, dc_req_valid, dc_req_write, dc_addr, dc_wdata,
               mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
        input  ic_req_ready, ic_rdata, ic_rvalid, ic_rlast,
               dc_req_ready, dc_wnext, dc_rdata, dc_rvalid, dc_last,
               mem_req_valid, mem_req_write, mem_addr, mem_wdata, mem_wvalid
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker
//   req[0]=icache, req[1]=dcache; last_grant = owner of the previous burst; grant = onehot pick
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] grant
);
    assign grant = &req ? (last_grant == OWN_IC ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst memory port between icache refill and dcache refill/writeback
//   clk, rst_n (synchronous, active-low); bus: mem_port_arbiter_if.master carrying both cache ports and the memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN * DATA_W / 8 - 1);
    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              req_q;
    logic              wvalid_q;
    logic [1:0]        grant;
    logic              rd_beat;
    logic              wr_beat;
    logic              last_beat;
    logic              own_ic;
    logic              own_dc;
    rr_arb2 u_rr_arb2 (
        .req        ({bus.dc_req_valid, bus.ic_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            last_grant <= OWN_IC;
            beat_cnt   <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            req_q      <= 1'b0;
            wvalid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    state   <= REQ;
                    owner   <= grant[1] ? OWN_DC : OWN_IC;
                    addr_q  <= (grant[1] ? bus.dc_addr : bus.ic_addr) & ALIGN_MASK;
                    write_q <= grant[1] & bus.dc_req_write;
                    req_q   <= 1'b1;
                end
                REQ: if (bus.mem_req_ready) begin
                    state    <= write_q ? WDATA : RDATA;
                    beat_cnt <= '0;
                    req_q    <= 1'b0;
                    wvalid_q <= write_q;
                end
                RDATA, WDATA: if (rd_beat | wr_beat) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (last_beat) begin
                        state      <= IDLE;
                        last_grant <= owner;
                        owner      <= OWN_NONE;
                        wvalid_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Beats only count in the matching data phase; stray memory strobes elsewhere are ignored.
    assign rd_beat   = state == RDATA && bus.mem_rvalid;
    assign wr_beat   = state == WDATA && bus.mem_wready;
    assign last_beat = beat_cnt == LAST_BEAT;
    assign own_ic    = owner == OWN_IC;
    assign own_dc    = owner == OWN_DC;
    assign bus.ic_req_ready  = req_q & bus.mem_req_ready & own_ic;
    assign bus.dc_req_ready  = req_q & bus.mem_req_ready & own_dc;
    assign bus.ic_rvalid     = rd_beat & own_ic;
    assign bus.ic_rdata      = bus.ic_rvalid ? bus.mem_rdata : '0;
    assign bus.ic_rlast      = bus.ic_rvalid & last_beat;
    assign bus.dc_rvalid     = rd_beat & own_dc;
    assign bus.dc_rdata      = bus.dc_rvalid ? bus.mem_rdata : '0;
    assign bus.dc_wnext      = wr_beat & wvalid_q;
    assign bus.dc_last       = (bus.dc_rvalid | bus.dc_wnext) & last_beat;
    assign bus.mem_req_valid = req_q;
    assign bus.mem_req_write = req_q & write_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = bus.dc_wdata;
    assign bus.mem_wvalid    = wvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, burst steering, write handshake, stall and reset abort
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    mem_port_arbiter_if bus ();
    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic grant(input bit dc, input logic [63:0] addr, input bit wr);
        bus.mem_req_ready = 1'b1;
        #1;
        chk("req_valid", bus.mem_req_valid, 1);
        chk("req_addr", bus.mem_addr, addr);
        chk("req_write", bus.mem_req_write, wr);
        chk("ic_req_ready", bus.ic_req_ready, !dc);
        chk("dc_req_ready", bus.dc_req_ready, dc);
        cyc();
        bus.mem_req_ready = 1'b0;
    endtask
    task automatic rd_burst(input bit dc, input logic [63:0] base);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = base + i;
            #1;
            chk(dc ? "dc_rvalid" : "ic_rvalid", dc ? bus.dc_rvalid : bus.ic_rvalid, 1);
            chk("rdata", dc ? bus.dc_rdata : bus.ic_rdata, base + i);
            chk("rlast", dc ? bus.dc_last : bus.ic_rlast, i == 3);
            chk("other_rvalid", dc ? bus.ic_rvalid : bus.dc_rvalid, 0);
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        #1;
        chk("idle_req_valid", bus.mem_req_valid, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [5:0] pat;
        int nwn;
        bus.ic_req_valid = 0; bus.ic_addr = 0;
        bus.dc_req_valid = 0; bus.dc_req_write = 0; bus.dc_addr = 0; bus.dc_wdata = 0;
        bus.mem_req_ready = 1; bus.mem_wready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'hdead;
        repeat (3) cyc();
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_wvalid", bus.mem_wvalid, 0);
        chk("rst_ic_rvalid", bus.ic_rvalid, 0);
        chk("rst_dc_rvalid", bus.dc_rvalid, 0);
        chk("rst_ic_req_ready", bus.ic_req_ready, 0);
        chk("rst_dc_req_ready", bus.dc_req_ready, 0);
        chk("rst_dc_wnext", bus.dc_wnext, 0);
        chk("rst_last", {bus.ic_rlast, bus.dc_last}, 0);
        bus.mem_req_ready = 0; bus.mem_wready = 0; bus.mem_rvalid = 0;
        // 1: icache alone, misaligned address
        rst_n = 1;
        bus.ic_req_valid = 1; bus.ic_addr = 64'h8000_0013;
        cyc();
        grant(0, 64'h8000_0000, 0);
        bus.ic_req_valid = 0;
        rd_burst(0, 64'h1100);
        // 2: simultaneous requests after reset, dcache first
        rst_n = 0;
        cyc();
        rst_n = 1;
        bus.ic_req_valid = 1; bus.ic_addr = 64'h1000;
        bus.dc_req_valid = 1; bus.dc_addr = 64'h2008;
        cyc();
        grant(1, 64'h2000, 0);
        bus.dc_req_valid = 0;
        rd_burst(1, 64'h2200);
        cyc();
        grant(0, 64'h1000, 0);
        bus.ic_req_valid = 0;
        rd_burst(0, 64'h3300);
        // 3: both held for four bursts, grants alternate
        bus.ic_req_valid = 1; bus.dc_req_valid = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            grant((k % 2) == 0, (k % 2) == 0 ? 64'h2000 : 64'h1000, 0);
            rd_burst((k % 2) == 0, 64'h4000 + 64'(k * 16));
        end
        bus.ic_req_valid = 0; bus.dc_req_valid = 0;
        // 4: dcache writeback with wready 1,0,0,1,1,1 and stray mem_rvalid
        bus.dc_req_valid = 1; bus.dc_req_write = 1; bus.dc_addr = 64'h3010;
        cyc();
        grant(1, 64'h3000, 1);
        bus.dc_req_valid = 0;
        pat = 6'b111001;
        nwn = 0;
        for (int i = 0; i < 6; i++) begin
            bus.mem_wready = pat[i];
            bus.dc_wdata   = 64'hA0 + 64'(nwn);
            bus.mem_rvalid = 1;
            #1;
            chk("mem_wvalid", bus.mem_wvalid, 1);
            chk("mem_wdata", bus.mem_wdata, 64'hA0 + 64'(nwn));
            chk("dc_wnext", bus.dc_wnext, pat[i]);
            chk("wr_dc_last", bus.dc_last, pat[i] && nwn == 3);
            chk("wr_dc_rvalid", bus.dc_rvalid, 0);
            nwn += int'(bus.dc_wnext);
            cyc();
        end
        bus.mem_wready = 0; bus.mem_rvalid = 0; bus.dc_req_write = 0;
        #1;
        chk("wr_done_wvalid", bus.mem_wvalid, 0);
        chk("wnext_count", nwn, 4);
        // 5: memory holds off the request for 10 cycles
        bus.ic_req_valid = 1; bus.ic_addr = 64'h4000_0027;
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk("stall_req_valid", bus.mem_req_valid, 1);
            chk("stall_addr", bus.mem_addr, 64'h4000_0020);
            chk("stall_ic_req_ready", bus.ic_req_ready, 0);
            cyc();
        end
        grant(0, 64'h4000_0020, 0);
        bus.ic_req_valid = 0;
        rd_burst(0, 64'h5500);
        // 6: reset during second read beat, then a fresh request
        bus.dc_req_valid = 1; bus.dc_addr = 64'h6000;
        cyc();
        grant(1, 64'h6000, 0);
        bus.dc_req_valid = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 64'h1;
        #1;
        chk("abort_beat0", bus.dc_rvalid, 1);
        cyc();
        bus.mem_rdata = 64'h2; rst_n = 0;
        #1;
        chk("abort_beat1", bus.dc_rvalid, 1);
        cyc();
        chk("abort_dc_rvalid", bus.dc_rvalid, 0);
        chk("abort_ic_rvalid", bus.ic_rvalid, 0);
        chk("abort_dc_last", bus.dc_last, 0);
        chk("abort_req_valid", bus.mem_req_valid, 0);
        chk("abort_wvalid", bus.mem_wvalid, 0);
        bus.mem_rvalid = 0; rst_n = 1;
        bus.ic_req_valid = 1; bus.ic_addr = 64'h7000;
        cyc();
        grant(0, 64'h7000, 0);
        bus.ic_req_valid = 0;
        rd_burst(0, 64'h8800);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
